// File: rtl/mvm_sequencer.sv
// Buffers a DEPTH-element input vector, then sequences weight-memory reads and a
// vsmac MAC so that it accumulates W*x, and hands the drained result downstream.
module mvm_sequencer #(
    parameter int SIZE        = 3,
    parameter int DEPTH       = 3,
    parameter int ADDR_W      = 2,
    parameter int MAC_LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    output logic                w_rd_en,
    output logic [ADDR_W-1:0]   w_addr,
    input  logic [8*SIZE-1:0]   w_data,
    output logic                mac_reset,
    output logic                mac_enable,
    output logic [8*SIZE-1:0]   mac_a,
    output logic [7:0]          mac_b,
    input  logic [8*SIZE-1:0]   mac_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [8*SIZE-1:0]   res_data,
    output logic                busy
);

    localparam int VW     = 8 * SIZE;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DCNT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DEPTH - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(MAC_LATENCY - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [DCNT_W-1:0]   dcnt_q;
    logic [7:0]          xbuf_q [DEPTH];
    logic [VW-1:0]       res_data_q;
    logic                w_rd_en_q;
    logic [ADDR_W-1:0]   w_addr_q;
    logic                mac_reset_q;
    logic                mac_enable_q;
    logic [7:0]          mac_b_q;
    logic                res_valid_q;

    assign idx_d = idx_q + IDX_W'(1);

    // Registered outputs are loaded for the state being entered, so each
    // transition also sets up the strobes/operands of the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            idx_q        <= '0;
            dcnt_q       <= '0;
            for (int i = 0; i < DEPTH; i++) xbuf_q[i] <= '0;
            res_data_q   <= '0;
            w_rd_en_q    <= 1'b0;
            w_addr_q     <= '0;
            mac_reset_q  <= 1'b0;
            mac_enable_q <= 1'b0;
            mac_b_q      <= '0;
            res_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        xbuf_q[idx_q] <= in_data;
                        if (idx_q == IDX_LAST) begin
                            idx_q       <= '0;
                            state_q     <= S_CLEAR;
                            mac_reset_q <= 1'b1;
                            w_rd_en_q   <= 1'b1;
                            w_addr_q    <= '0;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                S_CLEAR: begin
                    state_q      <= S_ISSUE;
                    mac_reset_q  <= 1'b0;
                    mac_enable_q <= 1'b1;
                    mac_b_q      <= xbuf_q[0];
                    w_rd_en_q    <= (DEPTH > 1);
                    w_addr_q     <= ADDR_W'(1);
                end
                S_ISSUE: begin
                    if (idx_q == IDX_LAST) begin
                        state_q   <= S_DRAIN;
                        idx_q     <= '0;
                        mac_b_q   <= '0;
                        w_rd_en_q <= 1'b0;
                        w_addr_q  <= '0;
                    end else begin
                        idx_q     <= idx_d;
                        mac_b_q   <= xbuf_q[idx_d];
                        // Column k+1 is fetched while k is issued; no read past the last column.
                        w_rd_en_q <= (idx_d != IDX_LAST);
                        w_addr_q  <= ADDR_W'(idx_d) + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (dcnt_q == DCNT_LAST) begin
                        dcnt_q       <= '0;
                        state_q      <= S_OUTPUT;
                        mac_enable_q <= 1'b0;
                        res_valid_q  <= 1'b1;
                        res_data_q   <= mac_out;
                    end else begin
                        dcnt_q <= dcnt_q + DCNT_W'(1);
                    end
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        state_q     <= S_LOAD;
                        res_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    // Decoded outputs are forced low while reset is asserted.
    assign in_ready   = (state_q == S_LOAD) && !reset;
    assign busy       = (state_q != S_LOAD) && !reset;
    assign mac_a      = ((state_q == S_ISSUE) && !reset) ? w_data : '0;
    assign w_rd_en    = w_rd_en_q;
    assign w_addr     = w_addr_q;
    assign mac_reset  = mac_reset_q;
    assign mac_enable = mac_enable_q;
    assign mac_b      = mac_b_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;

endmodule
